// File: rtl/frame_sequencer.sv
// Frame sequencer: per-frame start pulses, RUN-gated handshake, frame
// counting, stall timeout. Length check enabled by FRAME_SEQ_LENCHK_EN.
module frame_sequencer #(
  parameter int DATA_W     = 8,
  parameter int FRAME_W    = 16,
  parameter int FRAME_H    = 10,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_go,
  input  logic [7:0]        i_num_frames,
  output logic              o_src_start,
  input  logic [DATA_W-1:0] i_src_data,
  input  logic              i_src_valid,
  input  logic              i_src_last,
  output logic              o_src_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_valid,
  output logic              o_m_last,
  input  logic              i_m_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [7:0]        o_frame_cnt,
  output logic              o_err_len,
  output logic              o_err_timeout
);

  if (FRAME_W * FRAME_H > 65535 || GAP_CYCLES < 1 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("frame_sequencer: parameter out of range");
  end

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_target;
  logic [7:0]      r_frame_cnt;
  logic [15:0]     r_stall_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_err_to;

  logic            w_pass;
  logic            w_acc;
  logic            w_fend;
  logic            w_tout;
  logic            w_gap_end;
  logic [7:0]      w_frame_inc;

  assign w_pass      = (r_state == S_RUN);
  assign w_acc       = i_src_valid & o_src_ready;
  assign w_fend      = w_acc & i_src_last;
  assign w_tout      = ~w_acc & (r_stall_cnt == TO_LAST);
  assign w_gap_end   = (r_gap_cnt == GAP_LAST);
  assign w_frame_inc = r_frame_cnt + 8'd1;

  assign o_m_data      = i_src_data;
  assign o_m_valid     = i_src_valid & w_pass;
  assign o_m_last      = i_src_last & w_pass;
  assign o_src_ready   = i_m_ready & w_pass;
  assign o_src_start   = (r_state == S_START);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_frame_cnt   = r_frame_cnt;
  assign o_err_timeout = r_err_to;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; frame end beats a same-cycle timeout
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_go)
          w_state_nxt = (i_num_frames != 8'd0) ? S_START : S_DONE;
      end
      S_START: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_fend)
          w_state_nxt = (w_frame_inc == r_target) ? S_DONE : S_GAP;
        else if (w_tout)
          w_state_nxt = S_DONE;
      end
      S_GAP: begin
        if (w_gap_end) w_state_nxt = S_START;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Run target, frame/stall/gap counters and timeout flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_target    <= '0;
      r_frame_cnt <= '0;
      r_stall_cnt <= '0;
      r_gap_cnt   <= '0;
      r_err_to    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_go) begin
            r_target    <= i_num_frames;
            r_frame_cnt <= '0;
            r_err_to    <= 1'b0;
          end
        end
        S_START: r_stall_cnt <= '0;
        S_RUN: begin
          r_gap_cnt <= '0;
          if (w_acc)
            r_stall_cnt <= '0;
          else
            r_stall_cnt <= r_stall_cnt + 16'd1;
          if (w_fend)
            r_frame_cnt <= w_frame_inc;
          else if (w_tout)
            r_err_to <= 1'b1;
        end
        S_GAP:   r_gap_cnt <= r_gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef FRAME_SEQ_LENCHK_EN
  localparam logic [16:0] FSIZE = 17'(FRAME_W * FRAME_H);

  logic [15:0] r_pix_cnt;
  logic        r_err_len;
  logic [16:0] w_pix_inc;
  logic        w_len_bad;

  assign w_pix_inc = {1'b0, r_pix_cnt} + 17'd1;
  assign w_len_bad = i_src_last ? (w_pix_inc != FSIZE)
                                : (w_pix_inc == FSIZE);
  assign o_err_len = r_err_len;

  // Beat counter per frame; flags short, long and overlong frames
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pix_cnt <= '0;
      r_err_len <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (i_go) r_err_len <= 1'b0;
    end else if (r_state == S_START) begin
      r_pix_cnt <= '0;
    end else if (w_acc) begin
      if (r_pix_cnt != 16'hFFFF) r_pix_cnt <= w_pix_inc[15:0];
      if (w_len_bad) r_err_len <= 1'b1;
    end
  end
`else
  assign o_err_len = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized bench for frame_sequencer against a run/frame/gap model.
// Source model emits a numbered pixel pattern per frame.
module tb_frame_sequencer;

  localparam int DW  = 8;
  localparam int FW  = 16;
  localparam int FH  = 10;
  localparam int GAP = 4;
  localparam int TO  = 20;
  localparam int FSZ = FW * FH;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [7:0]    num;
  logic          src_start;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_last;
  logic          src_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic [7:0]    frame_cnt;
  logic          err_len;
  logic          err_timeout;

  frame_sequencer #(
    .DATA_W(DW), .FRAME_W(FW), .FRAME_H(FH),
    .GAP_CYCLES(GAP), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_go(go), .i_num_frames(num),
    .o_src_start(src_start), .i_src_data(src_data),
    .i_src_valid(src_valid), .i_src_last(src_last),
    .o_src_ready(src_ready), .o_m_data(m_data),
    .o_m_valid(m_valid), .o_m_last(m_last), .i_m_ready(m_ready),
    .o_busy(busy), .o_done(done), .o_frame_cnt(frame_cnt),
    .o_err_len(err_len), .o_err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  // reference model: what the run is doing this cycle
  bit md_start, md_run, md_done;
  int md_gap, md_frames, md_target, md_beats, md_idle;
  bit md_elen, md_eto;

  // source model
  bit s_on, s_vld, s_dead;
  int s_wait, s_pix, s_len, s_frame, s_lat;
  int unsigned s_stall;
  int len_q[$];

  // observations of DUT outputs
  int ob_beats, ob_lasts, ob_dones, ob_starts, ob_busy, done_cyc;
  int start_q[$];

  function automatic logic [7:0] pat(int f, int p);
    return 8'((p * 3 + f * 17) & 255);
  endfunction

  function automatic bit mbusy();
    return md_start | md_run | md_done | (md_gap > 0);
  endfunction

  function automatic bit exp_elen();
`ifdef FRAME_SEQ_LENCHK_EN
    return md_elen;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc_n, got, exp);
    end
  endtask

  task automatic clr_obs();
    ob_beats = 0; ob_lasts = 0; ob_dones = 0;
    ob_starts = 0; ob_busy = 0; done_cyc = -1;
    start_q.delete();
  endtask

  task automatic cyc();
    bit pass, acc, was_start;
    if (s_on && !s_dead && s_wait == 0 && !s_vld)
      s_vld = ($urandom_range(99) >= s_stall);
    src_valid = s_on && s_vld;
    src_data  = pat(s_frame, s_pix);
    src_last  = s_on && (s_pix == s_len - 1);
    @(negedge clk);
    pass = md_run;
    chk("src_start", 32'(src_start), 32'(md_start));
    chk("src_ready", 32'(src_ready), 32'(m_ready & pass));
    chk("m_valid", 32'(m_valid), 32'(src_valid & pass));
    chk("m_last", 32'(m_last), 32'(src_last & pass));
    chk("busy", 32'(busy), 32'(mbusy()));
    chk("done", 32'(done), 32'(md_done));
    chk("frame_cnt", 32'(frame_cnt), 32'(md_frames));
    chk("err_timeout", 32'(err_timeout), 32'(md_eto));
    chk("err_len", 32'(err_len), 32'(exp_elen()));
    if (src_valid && pass)
      chk("m_data", 32'(m_data), 32'(pat(s_frame, s_pix)));
    if (m_valid && m_ready) ob_beats++;
    if (m_valid && m_ready && m_last) ob_lasts++;
    if (done) begin ob_dones++; done_cyc = cyc_n; end
    if (src_start) begin ob_starts++; start_q.push_back(cyc_n); end
    if (busy) ob_busy++;
    @(posedge clk);
    acc = src_valid && m_ready && md_run;
    was_start = md_start;
    if (rst) begin
      md_start = 0; md_run = 0; md_done = 0; md_gap = 0;
      md_frames = 0; md_target = 0; md_beats = 0; md_idle = 0;
      md_elen = 0; md_eto = 0;
      s_on = 0; s_vld = 0;
    end else begin
      if (md_done) md_done = 0;
      else if (md_start) begin
        md_start = 0; md_run = 1; md_beats = 0; md_idle = 0;
      end else if (md_gap > 0) begin
        md_gap--;
        if (md_gap == 0) md_start = 1;
      end else if (md_run) begin
        if (acc) begin
          md_beats++;
          md_idle = 0;
          if (src_last) begin
            if (md_beats != FSZ) md_elen = 1;
            md_frames++;
            md_run = 0;
            if (md_frames == md_target) md_done = 1;
            else md_gap = GAP;
          end else if (md_beats == FSZ) md_elen = 1;
        end else begin
          md_idle++;
          if (md_idle == TO) begin
            md_eto = 1; md_run = 0; md_done = 1;
          end
        end
      end else if (go) begin
        md_frames = 0; md_elen = 0; md_eto = 0;
        md_target = int'(num);
        if (num != 8'd0) md_start = 1;
        else md_done = 1;
      end
      if (acc) begin
        s_vld = 0;
        if (src_last) begin s_on = 0; s_frame++; end
        s_pix++;
      end
      if (was_start) begin
        s_on = 1; s_pix = 0; s_wait = s_lat; s_vld = 0;
        s_len = (len_q.size() > 0) ? len_q.pop_front() : FSZ;
      end else if (s_on && s_wait > 0) s_wait--;
    end
    cyc_n++;
    #1;
  endtask

  task automatic run(int n, bit rnd_rdy, bit rnd_go, int budget);
    int k;
    go = 1'b1;
    num = 8'(n);
    m_ready = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
    cyc();
    go = 1'b0;
    k = 0;
    while (mbusy() && k < budget) begin
      m_ready = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
      go = rnd_go && ($urandom_range(15) == 0);
      if (go) num = 8'($urandom_range(255));
      cyc();
      k++;
    end
    go = 1'b0;
    if (mbusy()) chk("run_bound", 32'(k), 32'(budget + 1));
    m_ready = 1'b1;
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, go_cyc;
    rst = 1'b1; go = 1'b0; num = '0; m_ready = 1'b0;
    src_valid = 1'b0; src_last = 1'b0; src_data = '0;
    s_on = 0; s_vld = 0; s_dead = 0; s_wait = 0; s_pix = 0;
    s_len = FSZ; s_frame = 0; s_lat = 0; s_stall = 0;
    md_start = 0; md_run = 0; md_done = 0; md_gap = 0;
    md_frames = 0; md_target = 0; md_beats = 0; md_idle = 0;
    md_elen = 0; md_eto = 0;
    clr_obs();
    @(posedge clk); #1;
    cyc();
    cyc();
    rst = 1'b0;
    m_ready = 1'b1;
    cyc();

    // three clean frames, source one cycle late after each start
    clr_obs();
    s_lat = 1; s_stall = 0;
    run(3, 0, 0, 2000);
    chk("A_beats", 32'(ob_beats), 32'd480);
    chk("A_lasts", 32'(ob_lasts), 32'd3);
    chk("A_dones", 32'(ob_dones), 32'd1);
    chk("A_starts", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      chk("A_space1", 32'(start_q[1] - start_q[0]), 32'd166);
      chk("A_space2", 32'(start_q[2] - start_q[1]), 32'd166);
    end
    chk("A_frames", 32'(frame_cnt), 32'd3);
    chk("A_elen", 32'(err_len), 32'd0);
    chk("A_eto", 32'(err_timeout), 32'd0);

    // random backpressure, source stalls, stray go pulses
    clr_obs();
    s_lat = 0; s_stall = 30;
    run(3, 1, 1, 6000);
    chk("B_beats", 32'(ob_beats), 32'd480);
    chk("B_frames", 32'(frame_cnt), 32'd3);
    chk("B_elen", 32'(err_len), 32'd0);
    chk("B_eto", 32'(err_timeout), 32'd0);

    // short frame then overlong frame
    clr_obs();
    s_stall = 0;
    len_q.push_back(100);
    len_q.push_back(170);
    run(2, 0, 0, 2000);
    chk("C_lasts", 32'(ob_lasts), 32'd2);
    chk("C_frames", 32'(frame_cnt), 32'd2);
`ifdef FRAME_SEQ_LENCHK_EN
    chk("C_elen", 32'(err_len), 32'd1);
`else
    chk("C_elen", 32'(err_len), 32'd0);
`endif

    // dead source: timeout
    clr_obs();
    s_dead = 1;
    run(2, 0, 0, 200);
    s_dead = 0; s_on = 0; s_vld = 0;
    chk("D_dones", 32'(ob_dones), 32'd1);
    if (start_q.size() > 0)
      chk("D_when", 32'(done_cyc - start_q[0]), 32'd21);
    chk("D_frames", 32'(frame_cnt), 32'd0);
    chk("D_eto", 32'(err_timeout), 32'd1);

    // zero-frame run
    clr_obs();
    go_cyc = cyc_n;
    run(0, 0, 0, 10);
    chk("E_starts", 32'(ob_starts), 32'd0);
    chk("E_dones", 32'(ob_dones), 32'd1);
    chk("E_busy", 32'(ob_busy), 32'd1);
    chk("E_when", 32'(done_cyc - go_cyc), 32'd1);
    chk("E_eto", 32'(err_timeout), 32'd0);

    // reset during frame 2 of 3, then a clean single frame
    clr_obs();
    go = 1'b1; num = 8'd3;
    cyc();
    go = 1'b0;
    k = 0;
    while (!(md_frames == 1 && md_run && md_beats == 50) && k < 1000) begin
      cyc();
      k++;
    end
    chk("F_reach", 32'(md_beats), 32'd50);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("F_busy", 32'(busy), 32'd0);
    chk("F_frames", 32'(frame_cnt), 32'd0);
    chk("F_dones", 32'(ob_dones), 32'd0);
    run(1, 0, 0, 1000);
    chk("F_frames2", 32'(frame_cnt), 32'd1);
    chk("F_elen", 32'(err_len), 32'd0);
    chk("F_eto", 32'(err_timeout), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
